// File: rtl/arm_sc_control_unit_if.sv
// rtl/arm_sc_control_unit_if.sv - data memory request/ready handshake between control unit and memory
interface arm_sc_control_unit_if;
  logic mem_req;
  logic MemWrite;
  logic mem_ready;

  modport master (output mem_req, output MemWrite, input mem_ready);
  modport slave  (input mem_req, input MemWrite, output mem_ready);
endinterface

// File: rtl/arm_sc_control_unit.sv
// rtl/arm_sc_control_unit.sv - single-cycle ARM control unit: decode, NZCV flags, memory-stall sequencer, fault trap
module arm_sc_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [19:0]            Instr,
  input  logic [3:0]             ALUFlags,
  arm_sc_control_unit_if.master  mem,
  output logic [1:0]             RegSrc,
  output logic                   RegWrite,
  output logic [1:0]             ImmSrc,
  output logic                   ALUSrc,
  output logic [1:0]             ALUControl,
  output logic                   MemtoReg,
  output logic                   PCSrc,
  output logic                   pc_en,
  output logic                   fault,
  output logic [1:0]             fault_code,
  output logic [CNT_W-1:0]       retired
);

  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT, FAULT} state_t;

  state_t         state;
  logic [3:0]     flags;
  logic [WCW-1:0] wcnt;
  logic           wait_str;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_rn;

  logic [1:0] dec_regsrc, dec_immsrc, dec_aluctl;
  logic       dec_alusrc, dec_memtoreg, dec_regwrite, dec_str, dec_branch;
  logic       illegal, condex, flagw_nz, flagw_cv, mem_acc, active;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^Instr[7:4];

  always_comb begin
    dec_regsrc   = 2'b00;
    dec_immsrc   = 2'b00;
    dec_aluctl   = 2'b00;
    dec_alusrc   = 1'b0;
    dec_memtoreg = 1'b0;
    dec_regwrite = 1'b0;
    dec_str      = 1'b0;
    dec_branch   = 1'b0;
    illegal      = (cond == 4'b1111);
    case (op)
      2'b00: begin
        dec_alusrc   = funct[5];
        dec_regwrite = 1'b1;
        case (cmd)
          4'b0100: dec_aluctl = 2'b00;
          4'b0010: dec_aluctl = 2'b01;
          4'b0000: dec_aluctl = 2'b10;
          4'b1100: dec_aluctl = 2'b11;
          default: illegal    = 1'b1;
        endcase
      end
      2'b01: begin
        dec_alusrc = 1'b1;
        dec_immsrc = 2'b01;
        if (funct[0]) begin
          dec_memtoreg = 1'b1;
          dec_regwrite = 1'b1;
        end else begin
          dec_regsrc = 2'b10;
          dec_str    = 1'b1;
        end
      end
      2'b10: begin
        dec_regsrc = 2'b01;
        dec_immsrc = 2'b10;
        dec_alusrc = 1'b1;
        dec_branch = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign flagw_nz = (op == 2'b00) & funct[0];
  assign flagw_cv = flagw_nz & ((cmd == 4'b0100) | (cmd == 4'b0010));

  // Condition is always evaluated on the registered flags, never on ALUFlags.
  always_comb begin
    case (cond)
      4'h0:    condex = flags[2];
      4'h1:    condex = ~flags[2];
      4'h2:    condex = flags[1];
      4'h3:    condex = ~flags[1];
      4'h4:    condex = flags[3];
      4'h5:    condex = ~flags[3];
      4'h6:    condex = flags[0];
      4'h7:    condex = ~flags[0];
      4'h8:    condex = flags[1] & ~flags[2];
      4'h9:    condex = ~flags[1] | flags[2];
      4'hA:    condex = (flags[3] == flags[0]);
      4'hB:    condex = (flags[3] != flags[0]);
      4'hC:    condex = ~flags[2] & (flags[3] == flags[0]);
      4'hD:    condex = flags[2] | (flags[3] != flags[0]);
      4'hE:    condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  assign active  = ((state == EXEC) | (state == MEM_WAIT)) & ~illegal;
  assign mem_acc = (op == 2'b01) & condex;

  always_comb begin
    pc_en        = active & (mem_acc ? mem.mem_ready : 1'b1);
    mem.mem_req  = active & mem_acc;
    mem.MemWrite = (state == MEM_WAIT) ? (active & wait_str) : (active & mem_acc & dec_str);
    RegWrite     = pc_en & dec_regwrite & condex;
    PCSrc        = active & condex & (dec_branch | ((rd == 4'b1111) & dec_regwrite));
    MemtoReg     = pc_en & dec_memtoreg;
    RegSrc       = active ? dec_regsrc : 2'b00;
    ImmSrc       = active ? dec_immsrc : 2'b00;
    ALUSrc       = active & dec_alusrc;
    ALUControl   = active ? dec_aluctl : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      flags      <= 4'b0000;
      wcnt       <= '0;
      wait_str   <= 1'b0;
      retired    <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      case (state)
        IDLE: if (run) state <= EXEC;
        EXEC: begin
          if (illegal) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= 2'b01;
          end else if (mem_acc && !mem.mem_ready) begin
            state    <= MEM_WAIT;
            wcnt     <= WCW'(1);
            wait_str <= dec_str;
          end else if (!run) begin
            state <= IDLE;
          end
        end
        MEM_WAIT: begin
          if (mem.mem_ready) begin
            state <= run ? EXEC : IDLE;
            wcnt  <= '0;
          end else if (wcnt == WCW'(MEM_TIMEOUT - 1)) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= 2'b10;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        default: state <= FAULT;
      endcase
      // New flags only become visible to the instruction after this one.
      if (pc_en) begin
        retired <= retired + CNT_W'(1);
        if (flagw_nz && condex) flags[3:2] <= ALUFlags[3:2];
        if (flagw_cv && condex) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

endmodule

// File: doc/arm_sc_control_unit.md
Name: arm_sc_control_unit

Overview:
- Control unit and sequencer for the single-cycle ARM datapath.
- Decodes Instr[31:12] into the datapath control word: RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc.
- Holds the NZCV flag register and evaluates condition codes.
- Gates PC advance with pc_en, so LDR/STR can stall on a data memory with a mem_req/mem_ready handshake.
- Traps illegal instructions and memory timeouts into a sticky FAULT state.

Parameters:
- MEM_TIMEOUT, 16: max cycles a memory access may wait for mem_ready before faulting (≥2).
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset (0 = reset)
- run  input  1  1 = execute instructions; 0 = stop at the next instruction boundary
- Instr  input  20  Instr[31:12] of current instruction: cond, op, funct, Rd
- ALUFlags  input  4  combinational ALU flags {N,Z,C,V} = [3:0]
- mem_ready  input  1  data memory completes access this cycle
- RegSrc  output  2  register-address mux selects
- RegWrite  output  1  register file write enable
- ImmSrc  output  2  extend-unit format
- ALUSrc  output  1  0 = register, 1 = ExtImm
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- MemtoReg  output  1  result mux select
- PCSrc  output  1  1 = PC takes Result
- MemWrite  output  1  data memory write enable
- mem_req  output  1  data memory access request
- pc_en  output  1  PC register load enable (commit strobe)
- fault  output  1  sticky fault indicator
- fault_code  output  2  00 none, 01 illegal instruction, 10 memory timeout
- retired  output  CNT_W  committed-instruction count, including condition-failed instructions

Behaviour:
Reset:
- While reset = 0: state = IDLE; flags = 0000; wait counter = 0; retired = 0; fault = 0; fault_code = 00.
- While reset = 0: every control output is 0.
- Reset is honoured in any state, including MEM_WAIT and FAULT.

Decode (op = Instr[27:26], funct = Instr[25:20]):
- 00 data processing: RegSrc = 00; ImmSrc = 00; ALUSrc = funct[5]; RegWrite = 1.
- 00 ALUControl from cmd = funct[4:1]: 0100→00, 0010→01, 0000→10, 1100→11. Any other cmd is illegal.
- 01 memory: ALUSrc = 1; ImmSrc = 01; ALUControl = 00. funct[0] = 1 is LDR, funct[0] = 0 is STR.
- LDR: RegSrc = 00, MemtoReg = 1, RegWrite = 1.
- STR: RegSrc = 10, MemWrite = 1, RegWrite = 0.
- 10 branch: RegSrc = 01; ImmSrc = 10; ALUSrc = 1; ALUControl = 00; Branch = 1.
- 11: illegal.
- Flag write: FlagW[1] (NZ) = S; FlagW[0] (CV) = S & (cmd is ADD or SUB). S = funct[0], data processing only.
- PCSrc = CondEx & (Branch | (Rd == 1111 & RegWrite_decoded)).

Condition check (Instr[31:28]):
- Standard ARM EQ..AL against the registered flags, not ALUFlags.
- cond = 1111 is illegal.
- CondEx = 0 forces RegWrite, MemWrite, mem_req, PCSrc and flag update to 0.

FSM states: IDLE, EXEC, MEM_WAIT, FAULT. Control outputs are decode values in EXEC/MEM_WAIT and forced 0 in IDLE/FAULT.
- IDLE: pc_en = 0. If run = 1, go to EXEC next cycle.
- EXEC, illegal instruction: no commit; go to FAULT with fault_code = 01. The illegal check applies regardless of the condition code.
- EXEC, non-memory or CondEx = 0: commit this cycle (pc_en = 1, enables as decoded). Stay in EXEC, or go to IDLE if run = 0.
- EXEC, LDR/STR with CondEx = 1: mem_req = 1, MemWrite per decode.
  - mem_ready = 1: commit this cycle.
  - mem_ready = 0: go to MEM_WAIT, with pc_en = 0, RegWrite = 0, wait counter = 1.
- MEM_WAIT: mem_req and MemWrite held stable; pc_en = 0; RegWrite = 0.
  - mem_ready = 1: commit (pc_en = 1; RegWrite for LDR) and return to EXEC (or IDLE if run = 0).
  - Otherwise, if counter == MEM_TIMEOUT−1: go to FAULT with fault_code = 10.
  - Otherwise: counter increments.
  - run is ignored while in MEM_WAIT.
- FAULT: fault = 1; all enables 0; exit only by reset.

Commit edge:
- Flags update from ALUFlags per FlagW & CondEx.
- retired increments and wraps modulo 2^CNT_W.
- A commit and a flag update in the same cycle: the condition uses the old flags; the new flags apply to the next instruction.

Test Plan:
- ADDS imm 0xE2921000 with ALUFlags = 0100, commit; then BEQ 0x0A000002 → BEQ cycle: PCSrc = 1, pc_en = 1, RegWrite = 0.
- SUBNE 0x10433003 with flags Z = 1 → RegWrite = 0, pc_en = 1, flags unchanged, retired +1.
- LDR 0xE5910000 with mem_ready low 3 cycles then high → mem_req = 1 for 4 cycles; pc_en = 0, 0, 0, 1; RegWrite = 1 and MemtoReg = 1 only in cycle 4.
- MEM_TIMEOUT = 8, STR 0xE5810000, mem_ready never high → FAULT after 8 mem_req cycles, fault_code = 10, MemWrite drops to 0, no pc_en.
- Instr 0xEC000000 (op = 11) → next cycle fault = 1, fault_code = 01, retired unchanged.
- Reset pulled low during MEM_WAIT cycle 2 → immediately all outputs 0, flags 0000, retired 0; after release with run = 1, EXEC on the second edge.
